// File: rtl/jam_cost_arbiter_if.sv
// Bus bundle between the search engines, the Cost-table arbiter and the Cost table.
`default_nettype none

interface jam_cost_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [3*NREQ-1:0] req_w;
  logic [3*NREQ-1:0] req_j;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [6:0]        rsp_cost;
  logic [2:0]        W;
  logic [2:0]        J;
  logic [6:0]        Cost;

  // Requester/table side drives requests and table data.
  modport master (
    output req_valid, req_w, req_j, Cost,
    input  req_ready, rsp_valid, rsp_cost, W, J
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_w, req_j, Cost,
    output req_ready, rsp_valid, rsp_cost, W, J
  );
endinterface

`default_nettype wire

// File: rtl/jam_cost_arbiter.sv
// Round-robin arbiter sharing one Cost table between NREQ engines; 2-cycle read pipeline.
// Optional locked bursts of BURST beats when JAM_ARB_BURST_EN is defined.
`default_nettype none

module jam_cost_arbiter #(
  parameter int NREQ  = 2,
  parameter int BURST = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  jam_cost_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          rr_hit;
  logic [PW-1:0] rr_g;
  logic          gnt_v;
  logic [PW-1:0] gnt_g;

  logic [2:0]      w_q, j_q;
  logic            tag_v_q;
  logic [PW-1:0]   tag_g_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [6:0]      rsp_cost_q;

  // Descending scan so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    int idx;
    rr_hit = 1'b0;
    rr_g   = '0;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req_valid[idx]) begin
        rr_hit = 1'b1;
        rr_g   = PW'(idx);
      end
    end
  end

`ifdef JAM_ARB_BURST_EN
  localparam int       BW     = $clog2(BURST + 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] lock_g_q, lock_g_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          lock_hold;

  assign lock_hold = (state_q == S_LOCK) && bus.req_valid[lock_g_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lock_g_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      lock_g_q <= lock_g_d;
      beat_q   <= beat_d;
    end
  end

  // A lock whose owner has dropped valid falls straight back to round-robin this cycle.
  always_comb begin
    state_d  = state_q;
    lock_g_d = lock_g_q;
    beat_d   = beat_q;
    if (lock_hold) begin
      if (int'(beat_q) + 1 >= BURST) begin
        state_d = S_IDLE;
        beat_d  = '0;
      end else begin
        beat_d  = beat_q + 1'b1;
      end
    end else begin
      state_d = S_IDLE;
      beat_d  = '0;
      if (rr_hit && (BURST > 1)) begin
        state_d  = S_LOCK;
        lock_g_d = rr_g;
        beat_d   = BW'(1);
      end
    end
  end

  always_comb begin
    gnt_v = rr_hit;
    gnt_g = rr_g;
    if (lock_hold) begin
      gnt_v = 1'b1;
      gnt_g = lock_g_q;
    end
  end
`else
  assign gnt_v = rr_hit;
  assign gnt_g = rr_g;
`endif

  always_comb begin
    bus.req_ready = '0;
    if (gnt_v) bus.req_ready[gnt_g] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_v) rr_ptr_d = (int'(gnt_g) == NREQ - 1) ? '0 : gnt_g + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      w_q         <= '0;
      j_q         <= '0;
      tag_v_q     <= 1'b0;
      tag_g_q     <= '0;
      rsp_valid_q <= '0;
      rsp_cost_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tag_v_q  <= gnt_v;
      tag_g_q  <= gnt_g;
      if (gnt_v) begin
        w_q <= bus.req_w[3*int'(gnt_g) +: 3];
        j_q <= bus.req_j[3*int'(gnt_g) +: 3];
      end
      // Cost is valid while the tag sits in stage 1; idle slots leave rsp_cost untouched.
      rsp_valid_q <= tag_v_q ? (NREQ'(1) << tag_g_q) : '0;
      if (tag_v_q) rsp_cost_q <= bus.Cost;
    end
  end

  assign bus.W         = w_q;
  assign bus.J         = j_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_cost  = rsp_cost_q;
endmodule

`default_nettype wire

// File: tb/tb_jam_cost_arbiter.sv
// Randomized bench for jam_cost_arbiter against a queue-based reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_jam_cost_arbiter;
  localparam int NREQ  = 4;
  localparam int BURST = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  jam_cost_arbiter_if #(.NREQ(NREQ)) bus ();
  jam_cost_arbiter #(.NREQ(NREQ), .BURST(BURST)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [6:0] table_mem [64];
  assign bus.Cost = table_mem[{bus.W, bus.J}];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int              due;
    logic [NREQ-1:0] oh;
    logic [6:0]      cost;
  } rsp_t;

  rsp_t       pend[$];
  int         cyc = 0;
  int         m_rr = 0;
  int         m_lock = -1;
  int         m_beats = 0;
  logic [2:0] m_w = 0, m_j = 0;
  logic [6:0] m_cost_last = 0;

  function automatic int model_grant();
`ifdef JAM_ARB_BURST_EN
    if (m_lock >= 0 && bus.req_valid[m_lock]) return m_lock;
`endif
    for (int k = 0; k < NREQ; k++)
      if (bus.req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    return -1;
  endfunction

  initial begin
    forever begin
      int              g;
      bit              hold;
      logic [NREQ-1:0] exp_ready;
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend.delete();
        m_rr = 0; m_lock = -1; m_beats = 0;
        m_w = 0; m_j = 0; m_cost_last = 0;
        check("rst_W", 32'(bus.W), 0);
        check("rst_J", 32'(bus.J), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_cost", 32'(bus.rsp_cost), 0);
        continue;
      end
      hold = (m_lock >= 0) && bus.req_valid[m_lock];
      g = model_grant();
      exp_ready = (g >= 0) ? NREQ'(1) << g : '0;
      check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check("W", 32'(bus.W), 32'(m_w));
      check("J", 32'(bus.J), 32'(m_j));
      if (pend.size() > 0 && pend[0].due == cyc) begin
        check("rsp_valid", 32'(bus.rsp_valid), 32'(pend[0].oh));
        check("rsp_cost", 32'(bus.rsp_cost), 32'(pend[0].cost));
        m_cost_last = pend[0].cost;
        void'(pend.pop_front());
      end else begin
        check("rsp_valid_idle", 32'(bus.rsp_valid), 0);
        check("rsp_cost_hold", 32'(bus.rsp_cost), 32'(m_cost_last));
      end
      if (g >= 0) begin
        m_w = bus.req_w[3*g +: 3];
        m_j = bus.req_j[3*g +: 3];
        pend.push_back('{due: cyc + 2, oh: NREQ'(1) << g, cost: table_mem[{m_w, m_j}]});
        m_rr = (g + 1) % NREQ;
      end
      if (hold) begin
        m_beats++;
        if (m_beats == BURST) m_lock = -1;
      end else begin
        m_lock = -1;
        if (g >= 0 && BURST > 1) begin
          m_lock  = g;
          m_beats = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int i, input logic [2:0] w, input logic [2:0] j);
    bus.req_w[3*i +: 3] = w;
    bus.req_j[3*i +: 3] = j;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) table_mem[i] = 7'($urandom_range(0, 127));
    table_mem[3*8 + 5] = 7'd42;
    bus.req_valid = '0;
    bus.req_w = '0;
    bus.req_j = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, nothing pending
    @(negedge clk);
    check("t1_ready", 32'(bus.req_ready), 0);
    check("t1_W", 32'(bus.W), 0);
    check("t1_J", 32'(bus.J), 0);
    check("t1_rsp_valid", 32'(bus.rsp_valid), 0);

    // Single read (3,5) -> 42
    next_cycle();
    bus.req_valid = 4'b0001;
    set_req(0, 3'd3, 3'd5);
    @(negedge clk);
    check("t2_ready", 32'(bus.req_ready), 32'h1);
    next_cycle();
    bus.req_valid = '0;
    @(negedge clk);
    check("t2_W", 32'(bus.W), 3);
    check("t2_J", 32'(bus.J), 5);
    @(negedge clk);
    check("t2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("t2_rsp_cost", 32'(bus.rsp_cost), 42);

`ifndef JAM_ARB_BURST_EN
    // Two requesters continuously valid: alternate starting at rr_ptr=1
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      bus.req_valid = 4'b0011;
      set_req(0, 3'(i), 3'(i + 1));
      set_req(1, 3'(i + 2), 3'(i + 3));
      @(negedge clk);
      check("t3_alt", 32'(bus.req_ready), (i % 2 == 0) ? 32'h2 : 32'h1);
    end
    next_cycle();
    bus.req_valid = '0;
    repeat (2) next_cycle();

    // rr_ptr=2 with req1/req3 pending -> 3,1,3
    bus.req_valid = 4'b0010;
    @(negedge clk);
    check("t4_prime", 32'(bus.req_ready), 32'h2);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      bus.req_valid = 4'b1010;
      @(negedge clk);
      check("t4_seq", 32'(bus.req_ready), (i == 1) ? 32'h2 : 32'h8);
    end
`endif
    next_cycle();
    bus.req_valid = '0;
    repeat (2) next_cycle();

    // Reset the cycle after an accept
    bus.req_valid = 4'b0100;
    set_req(2, 3'd1, 3'd2);
    next_cycle();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    @(negedge clk);
    check("t5_no_rsp_rst", 32'(bus.rsp_valid[2]), 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("t5_first_gnt", 32'(bus.req_ready), 32'h1);
    check("t5_no_rsp_a", 32'(bus.rsp_valid[2]), 0);
    @(negedge clk);
    check("t5_no_rsp_b", 32'(bus.rsp_valid[2]), 0);
    next_cycle();
    bus.req_valid = '0;
    repeat (2) next_cycle();

`ifdef JAM_ARB_BURST_EN
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 2*BURST + 4; i++) begin
      bus.req_valid = (i >= 2*BURST + 3) ? 4'b0010 : 4'b0011;
      set_req(0, 3'(i), 3'(7 - i));
      set_req(1, 3'(i + 1), 3'(i));
      @(negedge clk);
      check("t6_burst", 32'(bus.req_ready),
            (i < BURST || (i >= 2*BURST && i < 2*BURST + 3)) ? 32'h1 : 32'h2);
      next_cycle();
    end
    bus.req_valid = '0;
    repeat (2) next_cycle();
`endif

    // Randomized traffic, occasional saturation and mid-stream reset
    for (int i = 0; i < 600; i++) begin
      bus.req_valid = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom);
      bus.req_w = 12'($urandom);
      bus.req_j = 12'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      next_cycle();
    end
    rst = 1'b0;
    bus.req_valid = '0;
    repeat (4) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

`default_nettype wire
